pong_match_ctrl: RTL and testbench

- Match sequencer for the Pong playfield renderer/datapath.
- Owns the game state (idle, serve, play, pause, point, game-over), serve countdown, scores, winner, and the timed bar power-ups (bar-height / bar-width enables, i.e. the renderer's 2-bit power-up input).
- The datapath reports scoring events; this block tells it when the ball may move and when to re-centre it.

---
 rtl/pong_match_ctrl_if.sv | 34 +++
 rtl/pong_match_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Match-control signal bundle between the Pong datapath/renderer and the match sequencer.
// slave = sequencer side, master = datapath/renderer side.
interface pong_match_ctrl_if #(
    parameter int SCORE_W = 6,
    parameter int TIMER_W = 10
);
    logic               frame_tick;
    logic               start_btn;
    logic               pause_btn;
    logic               point_l;
    logic               point_r;
    logic [1:0]         pw_req;
    logic [2:0]         state;
    logic               ball_run;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] lscore;
    logic [SCORE_W-1:0] rscore;
    logic [1:0]         winner;
    logic [1:0]         power_en;
    logic [TIMER_W-1:0] countdown;

    modport slave (
        input  frame_tick, start_btn, pause_btn, point_l, point_r, pw_req,
        output state, ball_run, ball_reset, serve_dir, lscore, rscore, winner,
               power_en, countdown
    );

    modport master (
        output frame_tick, start_btn, pause_btn, point_l, point_r, pw_req,
        input  state, ball_run, ball_reset, serve_dir, lscore, rscore, winner,
               power_en, countdown
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state, serve countdown, scores, winner and timed bar power-ups.
// All outputs registered; buttons and power-up requests act on rising edges only.
module pong_match_ctrl #(
    parameter int WIN_SCORE      = 11,
    parameter int SERVE_FRAMES   = 60,
    parameter int POWER_FRAMES   = 300,
    parameter int POWER_COOLDOWN = 600,
    parameter int SCORE_W        = 6,
    parameter int TIMER_W        = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    pong_match_ctrl_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PW_READY  = 2'd0,
        PW_ACTIVE = 2'd1,
        PW_COOL   = 2'd2
    } pw_e;

    state_e             state_q, state_d;
    logic               start_prev_q, pause_prev_q;
    logic [1:0]         pw_prev_q;
    logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_reset_q, ball_reset_d;
    logic               ball_run_q;
    logic [TIMER_W-1:0] countdown_q, countdown_d;
    pw_e                pw_st_q [2];
    pw_e                pw_st_d [2];
    logic [TIMER_W-1:0] pw_tmr_q [2];
    logic [TIMER_W-1:0] pw_tmr_d [2];
    logic [1:0]         power_en_q, power_en_d;

    logic       start_rise, pause_rise, timer_run;
    logic [1:0] pw_rise;

    assign start_rise = bus.start_btn & ~start_prev_q;
    assign pause_rise = bus.pause_btn & ~pause_prev_q;
    assign pw_rise    = bus.pw_req & ~pw_prev_q;
    // Power-up timers only run while the ball is live or about to be served.
    assign timer_run  = bus.frame_tick & ((state_q == S_PLAY) | (state_q == S_SERVE));

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        lscore_d     = lscore_q;
        rscore_d     = rscore_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;
        countdown_d  = countdown_q;
        case (state_q)
            S_IDLE: begin
                lscore_d = '0;
                rscore_d = '0;
                if (start_rise) begin
                    state_d      = S_SERVE;
                    ball_reset_d = 1'b1;
                    serve_dir_d  = 1'b1;
                    countdown_d  = TIMER_W'(SERVE_FRAMES);
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (countdown_q != '0) countdown_d = countdown_q - 1'b1;
                    else                   state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (bus.point_l) lscore_d = sat_inc(lscore_q);
                if (bus.point_r) rscore_d = sat_inc(rscore_q);
                if (bus.point_l | bus.point_r) state_d = S_POINT;
                else if (pause_rise)           state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause_rise) state_d = S_PLAY;
            end
            S_POINT: begin
                if ((lscore_q >= SCORE_W'(WIN_SCORE)) || (rscore_q >= SCORE_W'(WIN_SCORE))) begin
                    state_d  = S_OVER;
                    winner_d = {rscore_q >= SCORE_W'(WIN_SCORE), lscore_q >= SCORE_W'(WIN_SCORE)};
                end else begin
                    state_d      = S_SERVE;
                    ball_reset_d = 1'b1;
                    serve_dir_d  = (rscore_q > lscore_q);
                    countdown_d  = TIMER_W'(SERVE_FRAMES);
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d      = S_SERVE;
                    lscore_d     = '0;
                    rscore_d     = '0;
                    winner_d     = 2'b00;
                    ball_reset_d = 1'b1;
                    serve_dir_d  = 1'b1;
                    countdown_d  = TIMER_W'(SERVE_FRAMES);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pw_st_d[i]  = pw_st_q[i];
            pw_tmr_d[i] = pw_tmr_q[i];
            case (pw_st_q[i])
                PW_READY: begin
                    if (pw_rise[i] && (state_q == S_PLAY)) begin
                        pw_st_d[i]  = PW_ACTIVE;
                        pw_tmr_d[i] = TIMER_W'(POWER_FRAMES);
                    end
                end
                PW_ACTIVE: begin
                    if (timer_run) begin
                        if (pw_tmr_q[i] != '0) begin
                            pw_tmr_d[i] = pw_tmr_q[i] - 1'b1;
                        end else begin
                            pw_st_d[i]  = PW_COOL;
                            pw_tmr_d[i] = TIMER_W'(POWER_COOLDOWN);
                        end
                    end
                end
                PW_COOL: begin
                    if (timer_run) begin
                        if (pw_tmr_q[i] != '0) pw_tmr_d[i] = pw_tmr_q[i] - 1'b1;
                        else                   pw_st_d[i]  = PW_READY;
                    end
                end
                default: pw_st_d[i] = PW_READY;
            endcase
            // Leaving the match (idle or game over) disarms everything.
            if ((state_d == S_IDLE) || (state_d == S_OVER)) begin
                pw_st_d[i]  = PW_READY;
                pw_tmr_d[i] = '0;
            end
            power_en_d[i] = (pw_st_d[i] == PW_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
            pw_prev_q    <= 2'b11;
            lscore_q     <= '0;
            rscore_q     <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b1;
            ball_reset_q <= 1'b0;
            ball_run_q   <= 1'b0;
            countdown_q  <= '0;
            power_en_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                pw_st_q[i]  <= PW_READY;
                pw_tmr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.start_btn;
            pause_prev_q <= bus.pause_btn;
            pw_prev_q    <= bus.pw_req;
            lscore_q     <= lscore_d;
            rscore_q     <= rscore_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_reset_q <= ball_reset_d;
            ball_run_q   <= (state_q == S_PLAY);
            countdown_q  <= countdown_d;
            power_en_q   <= power_en_d;
            for (int i = 0; i < 2; i++) begin
                pw_st_q[i]  <= pw_st_d[i];
                pw_tmr_q[i] <= pw_tmr_d[i];
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.lscore     = lscore_q;
    assign bus.rscore     = rscore_q;
    assign bus.winner     = winner_q;
    assign bus.power_en   = power_en_q;
    assign bus.countdown  = countdown_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters (win 11, serve 60, power 300/600).
module tb_pong_match_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pong_match_ctrl_if #(.SCORE_W(6), .TIMER_W(10)) bus ();

    pong_match_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame tick followed by one quiet cycle.
    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
    endtask

    task automatic go_play();
        for (int k = 0; k < 100; k++) begin
            if (bus.state == 3'd2) break;
            tick();
        end
        total++;
        if (bus.state !== 3'd2) $display("FAIL go_play: state=%0d required 2 within 100 ticks", bus.state);
        else passed++;
    endtask

    task automatic test_reset();
        bus.start_btn = 1'b1;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        total++; if (bus.state !== 3'd0) $display("FAIL rst_state: got %0d want 0", bus.state); else passed++;
        total++; if (bus.serve_dir !== 1'b1) $display("FAIL rst_serve_dir: got %0b want 1", bus.serve_dir); else passed++;
        total++; if (bus.countdown !== 10'd0) $display("FAIL rst_countdown: got %0d want 0", bus.countdown); else passed++;
        total++; if ({bus.ball_run, bus.ball_reset, bus.winner, bus.power_en} !== 6'b0)
            $display("FAIL rst_flags: got %b want 000000", {bus.ball_run, bus.ball_reset, bus.winner, bus.power_en}); else passed++;
        total++; if ({bus.lscore, bus.rscore} !== 12'd0) $display("FAIL rst_scores: got %0d/%0d want 0/0", bus.lscore, bus.rscore); else passed++;
        bus.start_btn = 1'b0;
        cyc();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        total++; if (bus.state !== 3'd1) $display("FAIL start_state: got %0d want 1", bus.state); else passed++;
        total++; if (bus.ball_reset !== 1'b1) $display("FAIL start_ball_reset: got %0b want 1", bus.ball_reset); else passed++;
        total++; if (bus.countdown !== 10'd60) $display("FAIL start_countdown: got %0d want 60", bus.countdown); else passed++;
        cyc();
        total++; if (bus.ball_reset !== 1'b0) $display("FAIL start_ball_reset_pulse: got %0b want 0", bus.ball_reset); else passed++;
    endtask

    task automatic test_serve();
        for (int k = 1; k <= 60; k++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
            total++;
            if (bus.countdown !== 10'(60 - k)) $display("FAIL serve_countdown: tick %0d got %0d want %0d", k, bus.countdown, 60 - k);
            else passed++;
            cyc();
        end
        total++; if (bus.state !== 3'd1) $display("FAIL serve_hold: got state %0d want 1 after 60 ticks", bus.state); else passed++;
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        total++; if (bus.state !== 3'd2) $display("FAIL serve_to_play: got %0d want 2", bus.state); else passed++;
        total++; if (bus.ball_run !== 1'b0) $display("FAIL ball_run_lag: got %0b want 0", bus.ball_run); else passed++;
        cyc();
        total++; if (bus.ball_run !== 1'b1) $display("FAIL ball_run_on: got %0b want 1", bus.ball_run); else passed++;
    endtask

    task automatic test_point_r();
        bus.point_r = 1'b1;
        cyc();
        bus.point_r = 1'b0;
        total++; if (bus.rscore !== 6'd1) $display("FAIL pr_rscore: got %0d want 1", bus.rscore); else passed++;
        total++; if (bus.state !== 3'd4) $display("FAIL pr_state_point: got %0d want 4", bus.state); else passed++;
        cyc();
        total++; if (bus.state !== 3'd1) $display("FAIL pr_state_serve: got %0d want 1", bus.state); else passed++;
        total++; if (bus.serve_dir !== 1'b1) $display("FAIL pr_serve_dir: got %0b want 1", bus.serve_dir); else passed++;
        total++; if (bus.ball_reset !== 1'b1) $display("FAIL pr_ball_reset: got %0b want 1", bus.ball_reset); else passed++;
        total++; if (bus.countdown !== 10'd60) $display("FAIL pr_countdown: got %0d want 60", bus.countdown); else passed++;
        cyc();
    endtask

    task automatic test_win_draw();
        // From 0/1, nine right points and ten left points reach 10/10.
        for (int k = 0; k < 19; k++) begin
            go_play();
            if (k < 10) bus.point_l = 1'b1;
            else        bus.point_r = 1'b1;
            cyc();
            bus.point_l = 1'b0;
            bus.point_r = 1'b0;
            cyc();
        end
        total++; if ({bus.lscore, bus.rscore} !== {6'd10, 6'd10})
            $display("FAIL pre_win_scores: got %0d/%0d want 10/10", bus.lscore, bus.rscore); else passed++;
        total++; if (bus.serve_dir !== 1'b0) $display("FAIL tie_serve_dir: got %0b want 0", bus.serve_dir); else passed++;
        go_play();
        bus.point_l = 1'b1;
        bus.point_r = 1'b1;
        cyc();
        bus.point_l = 1'b0;
        bus.point_r = 1'b0;
        total++; if ({bus.lscore, bus.rscore} !== {6'd11, 6'd11})
            $display("FAIL win_scores: got %0d/%0d want 11/11", bus.lscore, bus.rscore); else passed++;
        cyc();
        total++; if (bus.state !== 3'd5) $display("FAIL win_state: got %0d want 5", bus.state); else passed++;
        total++; if (bus.winner !== 2'b11) $display("FAIL win_winner: got %b want 11", bus.winner); else passed++;
        repeat (3) cyc();
        total++; if (bus.ball_run !== 1'b0) $display("FAIL over_ball_run: got %0b want 0", bus.ball_run); else passed++;
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        total++; if (bus.state !== 3'd1) $display("FAIL restart_state: got %0d want 1", bus.state); else passed++;
        total++; if ({bus.lscore, bus.rscore, bus.winner} !== 14'd0)
            $display("FAIL restart_clear: got %0d/%0d w=%b want 0/0 w=00", bus.lscore, bus.rscore, bus.winner); else passed++;
        total++; if (bus.ball_reset !== 1'b1) $display("FAIL restart_ball_reset: got %0b want 1", bus.ball_reset); else passed++;
        cyc();
    endtask

    task automatic test_power();
        go_play();
        bus.pw_req = 2'b01;
        cyc();
        bus.pw_req = 2'b00;
        total++; if (bus.power_en !== 2'b01) $display("FAIL pw_arm: got %b want 01", bus.power_en); else passed++;
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        total++; if (bus.state !== 3'd3) $display("FAIL pause_enter: got %0d want 3", bus.state); else passed++;
        repeat (50) tick();
        bus.point_l = 1'b1;
        cyc();
        bus.point_l = 1'b0;
        total++; if (bus.lscore !== 6'd0) $display("FAIL pause_point_ignored: got %0d want 0", bus.lscore); else passed++;
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        total++; if (bus.state !== 3'd2) $display("FAIL pause_exit: got %0d want 2", bus.state); else passed++;
        // Timer loads 300 and expires on the tick after it reaches zero.
        repeat (300) tick();
        total++; if (bus.power_en !== 2'b01) $display("FAIL pw_hold_300: got %b want 01", bus.power_en); else passed++;
        tick();
        total++; if (bus.power_en !== 2'b00) $display("FAIL pw_expire: got %b want 00", bus.power_en); else passed++;
        tick();
        bus.pw_req = 2'b01;
        cyc();
        bus.pw_req = 2'b00;
        total++; if (bus.power_en !== 2'b00) $display("FAIL pw_cool_ignore: got %b want 00", bus.power_en); else passed++;
        repeat (599) tick();
        bus.pw_req = 2'b01;
        cyc();
        bus.pw_req = 2'b00;
        total++; if (bus.power_en !== 2'b00) $display("FAIL pw_cool_edge: got %b want 00", bus.power_en); else passed++;
        tick();
        bus.pw_req = 2'b01;
        cyc();
        bus.pw_req = 2'b00;
        total++; if (bus.power_en !== 2'b01) $display("FAIL pw_rearm: got %b want 01", bus.power_en); else passed++;
        bus.pw_req = 2'b10;
        cyc();
        bus.pw_req = 2'b00;
        total++; if (bus.power_en !== 2'b11) $display("FAIL pw_both: got %b want 11", bus.power_en); else passed++;
    endtask

    task automatic test_pause_vs_point();
        bus.pause_btn = 1'b1;
        bus.point_l   = 1'b1;
        cyc();
        bus.point_l   = 1'b0;
        total++; if (bus.lscore !== 6'd1) $display("FAIL pp_lscore: got %0d want 1", bus.lscore); else passed++;
        total++; if (bus.state !== 3'd4) $display("FAIL pp_state: got %0d want 4", bus.state); else passed++;
        cyc();
        bus.pause_btn = 1'b0;
        total++; if (bus.state !== 3'd1) $display("FAIL pp_serve: got %0d want 1", bus.state); else passed++;
        total++; if (bus.serve_dir !== 1'b0) $display("FAIL pp_serve_dir: got %0b want 0", bus.serve_dir); else passed++;
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++; if (bus.state !== 3'd0) $display("FAIL mid_rst_state: got %0d want 0", bus.state); else passed++;
        total++; if ({bus.lscore, bus.power_en, bus.countdown} !== 18'd0)
            $display("FAIL mid_rst_vals: got l=%0d pw=%b cd=%0d want 0", bus.lscore, bus.power_en, bus.countdown); else passed++;
        total++; if (bus.serve_dir !== 1'b1) $display("FAIL mid_rst_dir: got %0b want 1", bus.serve_dir); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", bus.state);
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.point_l    = 1'b0;
        bus.point_r    = 1'b0;
        bus.pw_req     = 2'b00;
        test_reset();
        test_serve();
        test_point_r();
        test_win_draw();
        test_power();
        test_pause_vs_point();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
